// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding controller for the five-stage core: load-use and branch-operand
// hazards, multi-cycle divide sequencing, memory-port stalls and exception flush ordering.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 34
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [4:0] rs_d_i,
    input  logic [4:0] rt_d_i,
    input  logic       branch_d_i,
    input  logic [4:0] rs_e_i,
    input  logic [4:0] rt_e_i,
    input  logic [4:0] dst_e_i,
    input  logic       wreg_e_i,
    input  logic       rmem_e_i,
    input  logic       div_e_i,
    input  logic [4:0] dst_m_i,
    input  logic [4:0] dst_w_i,
    input  logic       wreg_m_i,
    input  logic       rmem_m_i,
    input  logic       wreg_w_i,
    input  logic       istall_i,
    input  logic       dstall_i,
    input  logic       except_m_i,
    output logic       stall_f_o,
    output logic       stall_d_o,
    output logic       stall_e_o,
    output logic       stall_m_o,
    output logic       flush_d_o,
    output logic       flush_e_o,
    output logic       flush_m_o,
    output logic       flush_w_o,
    output logic       exc_redirect_o,
    output logic       div_done_o,
    output logic [1:0] fwd_a_e_o,
    output logic [1:0] fwd_b_e_o,
    output logic       fwd_a_d_o,
    output logic       fwd_b_d_o
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_DIV      = 2'd1;
    localparam logic [1:0] S_EXC_WAIT = 2'd2;
    localparam logic [5:0] CNT_LOAD   = 6'(DIV_CYCLES - 2);

    logic [1:0] r_state, w_state_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;

    logic w_e_rs, w_e_rt, w_m_rs, w_m_rt;
    logic w_lu, w_mem_busy, w_exc_req;
    logic [1:0] w_fwd_a_e, w_fwd_b_e;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_m, w_flush_w;
    logic w_redirect, w_div_done;

    function automatic logic f_match(input logic wr, input logic [4:0] dst, input logic [4:0] src);
        return wr && (dst != 5'd0) && (dst == src);
    endfunction

    assign w_fwd_a_e = f_match(wreg_m_i, dst_m_i, rs_e_i) ? 2'b10 :
                       f_match(wreg_w_i, dst_w_i, rs_e_i) ? 2'b01 : 2'b00;
    assign w_fwd_b_e = f_match(wreg_m_i, dst_m_i, rt_e_i) ? 2'b10 :
                       f_match(wreg_w_i, dst_w_i, rt_e_i) ? 2'b01 : 2'b00;

    assign w_e_rs = f_match(wreg_e_i, dst_e_i, rs_d_i);
    assign w_e_rt = f_match(wreg_e_i, dst_e_i, rt_d_i);
    assign w_m_rs = f_match(wreg_m_i, dst_m_i, rs_d_i);
    assign w_m_rt = f_match(wreg_m_i, dst_m_i, rt_d_i);

    // A load in MEM cannot feed the ID comparator, so branches wait for it instead.
    assign w_lu = (rmem_e_i & (w_e_rs | w_e_rt)) |
                  (branch_d_i & (w_e_rs | w_e_rt | (rmem_m_i & (w_m_rs | w_m_rt))));

    assign w_mem_busy = istall_i | dstall_i;
    assign w_exc_req  = except_m_i | (r_state == S_EXC_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_f   = 1'b0;
        w_stall_d   = 1'b0;
        w_stall_e   = 1'b0;
        w_stall_m   = 1'b0;
        w_flush_d   = 1'b0;
        w_flush_e   = 1'b0;
        w_flush_m   = 1'b0;
        w_flush_w   = 1'b0;
        w_redirect  = 1'b0;
        w_div_done  = 1'b0;
        if (w_exc_req && !w_mem_busy) begin
            {w_flush_d, w_flush_e, w_flush_m, w_flush_w} = 4'b1111;
            w_redirect  = 1'b1;
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
        end else if (w_exc_req) begin
            {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
            w_flush_w   = 1'b1;
            w_state_nxt = S_EXC_WAIT;
            w_cnt_nxt   = '0;
        end else if (w_mem_busy) begin
            // Memory stall freezes state and counter, pausing any divide.
            {w_stall_f, w_stall_d, w_stall_e, w_stall_m} = 4'b1111;
            w_flush_w = 1'b1;
        end else if (r_state == S_DIV && r_cnt != 6'd0) begin
            {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
            w_flush_m = 1'b1;
            w_cnt_nxt = r_cnt - 6'd1;
        end else if (r_state == S_DIV) begin
            w_div_done  = 1'b1;
            w_state_nxt = S_RUN;
            w_stall_f   = w_lu;
            w_stall_d   = w_lu;
            w_flush_e   = w_lu;
        end else if (div_e_i) begin
            {w_stall_f, w_stall_d, w_stall_e} = 3'b111;
            w_flush_m   = 1'b1;
            w_state_nxt = S_DIV;
            w_cnt_nxt   = CNT_LOAD;
        end else begin
            w_stall_f = w_lu;
            w_stall_d = w_lu;
            w_flush_e = w_lu;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign stall_f_o      = rst_i & w_stall_f;
    assign stall_d_o      = rst_i & w_stall_d;
    assign stall_e_o      = rst_i & w_stall_e;
    assign stall_m_o      = rst_i & w_stall_m;
    assign flush_d_o      = rst_i & w_flush_d;
    assign flush_e_o      = rst_i & w_flush_e;
    assign flush_m_o      = rst_i & w_flush_m;
    assign flush_w_o      = rst_i & w_flush_w;
    assign exc_redirect_o = rst_i & w_redirect;
    assign div_done_o     = rst_i & w_div_done;
    assign fwd_a_e_o      = rst_i ? w_fwd_a_e : 2'b00;
    assign fwd_b_e_o      = rst_i ? w_fwd_b_e : 2'b00;
    assign fwd_a_d_o      = rst_i & w_m_rs & ~rmem_m_i;
    assign fwd_b_d_o      = rst_i & w_m_rt & ~rmem_m_i;

endmodule
